risc_spm_control_unit: RTL
==========================

# risc_spm_control_unit

Sequencing controller for the RISC stored-program machine. It steps the processor through fetch, decode and execute for each 8-bit instruction. On every cycle it drives the register, PC, IR, address-register and memory-write strobes, the two bus-mux selects, and the ALU operation select. It sits between the instruction register and Reg_Z flag on one side and the datapath (register file, ALU, bus muxes, memory) on the other.

## Interface
- No parameters; widths are fixed by the instruction set (8-bit word, 4-bit opcode, 2-bit register fields).
- clk  input  1  system clock; all state changes occur on its rising edge
- rst_n  input  1  synchronous active-low reset
- instruction  input  8  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
- zero  input  1  registered ALU zero flag (Reg_Z output)
- load_r  output  4  one-hot register-file load enable, bit n loads Rn
- load_pc  output  1  load PC from Bus_2
- inc_pc  output  1  PC increment
- load_ir  output  1  load IR from Bus_2
- load_add_r  output  1  load memory address register from Bus_2
- load_reg_y  output  1  load ALU operand register Y from Bus_2
- load_reg_z  output  1  load zero-flag register from ALU_Zflag
- sel_bus_1  output  3  Bus_1 source: 0..3 = R0..R3, 4 = PC, others reserved
- sel_bus_2  output  2  Bus_2 source: 0 = ALU_out, 1 = Bus_1, 2 = memory word
- alu_sel  output  4  ALU operation, equal to instruction[7:4] in every state
- write  output  1  memory write strobe
- halted  output  1  high while in S_HALT

## Operation
- State register is updated on posedge clk. Outputs are a combinational decode of (state, instruction, zero).
- In every state, any strobe not listed for that state is 0, and the selects are 0.
- Opcode encodings:
  - NOP = 0, ADD = 1, SUB = 2, AND = 3, NOT = 4
  - RD = 5, WR = 6, BR = 7, BRZ = 8
- S_IDLE: no strobes → S_FET1.
- S_FET1: sel_bus_1 = PC, sel_bus_2 = Bus_1, load_add_r → S_FET2.
- S_FET2: sel_bus_2 = mem, load_ir, inc_pc → S_DEC.
- S_DEC, by opcode:
  - NOP: no strobes → S_FET1.
  - ADD/SUB/AND: sel_bus_1 = src, sel_bus_2 = Bus_1, load_reg_y → S_EX1.
  - NOT: sel_bus_1 = src, sel_bus_2 = ALU, load_reg_z, load_r[dest] → S_FET1.
  - RD/WR/BR: sel_bus_1 = PC, sel_bus_2 = Bus_1, load_add_r → S_RD1 / S_WR1 / S_BR1 respectively.
  - BRZ, zero = 1: same strobes as BR → S_BR1.
  - BRZ, zero = 0: inc_pc only (skips the address word) → S_FET1.
- S_EX1: sel_bus_1 = dest, sel_bus_2 = ALU, load_reg_z, load_r[dest] → S_FET1. Arithmetic wraps modulo 256. SUB computes dest − src.
- S_RD1: sel_bus_2 = mem, load_add_r, inc_pc → S_RD2.
- S_RD2: sel_bus_2 = mem, load_r[dest] → S_FET1.
- S_WR1: sel_bus_2 = mem, load_add_r, inc_pc → S_WR2.
- S_WR2: sel_bus_1 = src, write → S_FET1.
- S_BR1: sel_bus_2 = mem, load_add_r → S_BR2.
- S_BR2: sel_bus_2 = mem, load_pc → S_FET1.
- Opcodes 9..15: behaviour is set by the configuration macro (see below).
- S_HALT: no strobes, halted = 1. The controller stays in S_HALT until reset.
- At most one load_r bit is set in any cycle.

## Timing
- Reset: when rst_n = 0 at a posedge, state becomes S_IDLE. All outputs are then 0 (alu_sel still follows instruction).
- Reset takes priority over every transition, including mid-instruction. No write is issued in the cycle after a reset edge.
- Cycles per instruction, counting from S_FET1 (S_FET1, S_FET2 and S_DEC included in each count):
  - NOP and NOT: 3
  - ADD/SUB/AND: 4
  - RD and WR: 5
  - BR, and BRZ taken: 5
  - BRZ not taken: 3
- zero is sampled only in S_DEC of a BRZ. It reflects the last ALU instruction.

## Configuration
- The macro CTRL_ILLEGAL_HALT_EN controls handling of opcodes 9..15.
- Defined: opcodes 9..15 in S_DEC → S_HALT, and halted asserts on the next cycle.
- Undefined: opcodes 9..15 decode as NOP (→ S_FET1). halted is tied to 0 and S_HALT is unreachable.

## Structure
- Shared package risc_spm_pkg holds:
  - opcode constants
  - state enumeration (4-bit encoding)
  - Bus_1 / Bus_2 select constants
  - instruction field positions
- The ALU imports the same opcode constants from this package.
- Single module: one sequential state-register process plus one combinational next-state/output process. No sub-module is needed.

## Test plan
- Reset: rst_n = 0 for 2 cycles then 1 → S_IDLE; all strobes 0; load_add_r asserts exactly 2 cycles after release (S_FET1).
- ADD R1, R2 with R1 = 3, R2 = 5 (instruction 0x16):
  - S_DEC: sel_bus_1 = 1, load_reg_y.
  - S_EX1: sel_bus_1 = 2, sel_bus_2 = 0, load_r = 4'b0100, load_reg_z.
  - Next cycle is S_FET1 (4 cycles total).
- WR R3 (instruction 0x6C): write = 1 only in S_WR2, with sel_bus_1 = 3; inc_pc pulses in S_FET2 and S_WR1.
- BRZ:
  - Instruction 0x80 with zero = 0: inc_pc in S_DEC, then S_FET1 (3 cycles).
  - Same instruction with zero = 1: load_pc in S_BR2 (5 cycles).
- Reset mid-instruction: rst_n = 0 in S_WR1 → write never asserts; controller restarts at S_IDLE.
- Opcode 0xF0:
  - With CTRL_ILLEGAL_HALT_EN: halted = 1 from the cycle after S_DEC and stays 1 for 10+ cycles.
  - Without: the controller returns to S_FET1 after 3 cycles.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC stored-program machine: opcodes, controller states,
// bus select codes and instruction field positions.
package risc_spm_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [2:0] BUS1_PC   = 3'd4;
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int SRC_MSB = 3;
  localparam int SRC_LSB = 2;
  localparam int DST_MSB = 1;
  localparam int DST_LSB = 0;

endpackage

// File: rtl/risc_spm_control_unit.sv
// Fetch/decode/execute sequencer for the RISC-SPM. Opcodes 9..15 halt the machine
// when CTRL_ILLEGAL_HALT_EN is defined, otherwise they behave as NOP.
//   state  | meaning
//   S_IDLE | after reset, nothing driven
//   S_FET1 | PC -> address register
//   S_FET2 | memory -> IR, PC++
//   S_DEC  | decode opcode, first execute step
//   S_EX1  | ALU result -> Rdest, Reg_Z
//   S_RD1  | operand address word -> address register, PC++
//   S_RD2  | memory -> Rdest
//   S_WR1  | operand address word -> address register, PC++
//   S_WR2  | Rsrc -> memory
//   S_BR1  | target address word -> address register
//   S_BR2  | memory -> PC
//   S_HALT | stopped until reset
module risc_spm_control_unit
  import risc_spm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instruction,
  input  logic       zero,
  output logic [3:0] load_r,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       load_ir,
  output logic       load_add_r,
  output logic       load_reg_y,
  output logic       load_reg_z,
  output logic [2:0] sel_bus_1,
  output logic [1:0] sel_bus_2,
  output logic [3:0] alu_sel,
  output logic       write,
  output logic       halted
);

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;

  assign opcode  = instruction[OP_MSB:OP_LSB];
  assign src     = instruction[SRC_MSB:SRC_LSB];
  assign dest    = instruction[DST_MSB:DST_LSB];
  assign alu_sel = opcode;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    sel_bus_1  = 3'd0;
    sel_bus_2  = 2'd0;
    write      = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        sel_bus_1  = BUS1_PC;
        sel_bus_2  = BUS2_BUS1;
        load_add_r = 1'b1;
        state_d    = S_FET2;
      end
      S_FET2: begin
        sel_bus_2 = BUS2_MEM;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_d   = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = BUS2_BUS1;
            load_reg_y = 1'b1;
            state_d    = S_EX1;
          end
          OP_NOT: begin
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = BUS2_ALU;
            load_reg_z = 1'b1;
            load_r     = 4'b0001 << dest;
            state_d    = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_bus_1  = BUS1_PC;
            sel_bus_2  = BUS2_BUS1;
            load_add_r = 1'b1;
            state_d    = (opcode == OP_RD) ? S_RD1 :
                         (opcode == OP_WR) ? S_WR1 : S_BR1;
          end
          OP_BRZ: begin
            if (zero) begin
              sel_bus_1  = BUS1_PC;
              sel_bus_2  = BUS2_BUS1;
              load_add_r = 1'b1;
              state_d    = S_BR1;
            end else begin
              // not taken: step PC over the branch target word
              inc_pc  = 1'b1;
              state_d = S_FET1;
            end
          end
          default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_FET1;
`endif
          end
        endcase
      end
      S_EX1: begin
        sel_bus_1  = {1'b0, dest};
        sel_bus_2  = BUS2_ALU;
        load_reg_z = 1'b1;
        load_r     = 4'b0001 << dest;
        state_d    = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel_bus_2  = BUS2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        sel_bus_2 = BUS2_MEM;
        load_r    = 4'b0001 << dest;
        state_d   = S_FET1;
      end
      S_WR2: begin
        sel_bus_1 = {1'b0, src};
        write     = 1'b1;
        state_d   = S_FET1;
      end
      S_BR1: begin
        sel_bus_2  = BUS2_MEM;
        load_add_r = 1'b1;
        state_d    = S_BR2;
      end
      S_BR2: begin
        sel_bus_2 = BUS2_MEM;
        load_pc   = 1'b1;
        state_d   = S_FET1;
      end
      S_HALT: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        halted = 1'b1;
`endif
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
